// File: rtl/num_guess_judge.sv
// rtl/num_guess_judge.sv - three-digit guess judge: A/B scoring, failure lockout, solved latch
module num_guess_judge #(
    parameter logic [3:0]  SECRET1     = 4'd1,
    parameter logic [3:0]  SECRET2     = 4'd2,
    parameter logic [3:0]  SECRET3     = 4'd3,
    parameter int unsigned MAX_TRY     = 3,
    parameter logic [23:0] LOCK_CYCLES = 24'd10_000_000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] iNum1,
    input  logic [3:0] iNum2,
    input  logic [3:0] iNum3,
    input  logic       iNumRdy,
    output logic [1:0] oA,
    output logic [1:0] oB,
    output logic [2:0] oLED
);

    typedef enum logic [1:0] {IDLE, CHECK, DONE, LOCK} state_t;

    // Index 2 is the hundreds digit so guess and secret line up position by position.
    localparam logic [2:0][3:0] SECRET    = {SECRET1, SECRET2, SECRET3};
    localparam logic [2:0]      MAX_TRY_C = 3'(MAX_TRY);
    localparam logic [23:0]     LOCK_LOAD = LOCK_CYCLES - 24'd1;

    state_t          state_q, state_d;
    logic            rdy_q;
    logic [2:0][3:0] guess_q, guess_d;
    logic [1:0]      a_q, a_d, b_q, b_d;
    logic [2:0]      led_q, led_d;
    logic [2:0]      fail_q, fail_d;
    logic [23:0]     timer_q, timer_d;

    logic            guess_edge;
    logic            bad_digit, hit;
    logic [1:0]      a_sum, score_a, score_b;
    logic [2:0]      b_sum;

    assign guess_edge = iNumRdy & ~rdy_q;

    always_comb begin
        bad_digit = 1'b0;
        hit       = 1'b0;
        a_sum     = '0;
        b_sum     = '0;
        for (int i = 0; i < 3; i++) begin
            if (guess_q[i] > 4'd9) bad_digit = 1'b1;
            if (guess_q[i] == SECRET[i]) begin
                a_sum = a_sum + 2'd1;
            end else begin
                hit = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    if (j != i && guess_q[i] == SECRET[j]) hit = 1'b1;
                end
                if (hit) b_sum = b_sum + 3'd1;
            end
        end
        score_a = bad_digit ? 2'd0 : a_sum;
        score_b = bad_digit ? 2'd0 : ((b_sum > 3'd3) ? 2'd3 : b_sum[1:0]);
    end

    always_comb begin
        state_d = state_q;
        guess_d = guess_q;
        a_d     = a_q;
        b_d     = b_q;
        led_d   = led_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (guess_edge) begin
                    guess_d = {iNum1, iNum2, iNum3};
                    state_d = CHECK;
                end
            end
            CHECK: begin
                a_d      = score_a;
                b_d      = score_b;
                led_d[0] = 1'b1;
                if (score_a == 2'd3) begin
                    state_d  = DONE;
                    led_d[1] = 1'b1;
                    fail_d   = '0;
                end else if (fail_q + 3'd1 == MAX_TRY_C) begin
                    state_d  = LOCK;
                    led_d[2] = 1'b1;
                    fail_d   = '0;
                    timer_d  = LOCK_LOAD;
                end else begin
                    fail_d  = fail_q + 3'd1;
                    state_d = IDLE;
                end
            end
            LOCK: begin
                // The terminal-count cycle is still spent in LOCK, giving LOCK_CYCLES in total.
                if (timer_q == '0) begin
                    state_d  = IDLE;
                    led_d[2] = 1'b0;
                end else begin
                    timer_d = timer_q - 24'd1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            guess_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            led_q   <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= iNumRdy;
            guess_q <= guess_d;
            a_q     <= a_d;
            b_q     <= b_d;
            led_q   <= led_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    assign oA   = a_q;
    assign oB   = b_q;
    assign oLED = led_q;

endmodule

// File: tb/tb_num_guess_judge.sv
// tb/tb_num_guess_judge.sv - randomized and directed checks of num_guess_judge against a behavioural model
module tb_num_guess_judge;

    localparam int SECRET_NUM = 123;
    localparam int MAX_TRY    = 3;
    localparam int LOCK_LEN   = 8;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] iNum1 = '0, iNum2 = '0, iNum3 = '0;
    logic       iNumRdy = 1'b0;
    logic [1:0] oA, oB;
    logic [2:0] oLED;

    int n_checks = 0;
    int n_errors = 0;

    int m_a, m_b, m_led, m_fails;
    bit m_solved, m_locked;

    num_guess_judge #(
        .SECRET1(4'd1), .SECRET2(4'd2), .SECRET3(4'd3),
        .MAX_TRY(MAX_TRY), .LOCK_CYCLES(24'd8)
    ) dut (
        .CLK(CLK), .reset(reset),
        .iNum1(iNum1), .iNum2(iNum2), .iNum3(iNum3), .iNumRdy(iNumRdy),
        .oA(oA), .oB(oB), .oLED(oLED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bulls/cows scoring straight from the rules, with the secret held as a decimal number.
    function automatic void score(input int g1, input int g2, input int g3,
                                  output int a, output int b);
        int sd[3];
        int gd[3];
        sd[0] = SECRET_NUM / 100; sd[1] = (SECRET_NUM / 10) % 10; sd[2] = SECRET_NUM % 10;
        gd[0] = g1; gd[1] = g2; gd[2] = g3;
        a = 0;
        b = 0;
        if (g1 > 9 || g2 > 9 || g3 > 9) return;
        foreach (gd[i]) begin
            if (gd[i] == sd[i]) a++;
            else if (gd[i] == sd[(i + 1) % 3] || gd[i] == sd[(i + 2) % 3]) b++;
        end
        if (b > 3) b = 3;
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_led = 0; m_fails = 0; m_solved = 0; m_locked = 0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        model_reset();
        check("reset_a", oA, 0);
        check("reset_b", oB, 0);
        check("reset_led", oLED, 0);
        reset = 1'b0;
        @(negedge CLK);
    endtask

    // Leaves the caller on the negedge after the result edge.
    task automatic drive_guess(input int g1, input int g2, input int g3);
        iNumRdy = 1'b0;
        @(negedge CLK);
        iNum1 = 4'(g1); iNum2 = 4'(g2); iNum3 = 4'(g3);
        iNumRdy = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        iNumRdy = 1'b0;
    endtask

    task automatic run_guess(input int g1, input int g2, input int g3, input bit wait_lock);
        int a, b;
        drive_guess(g1, g2, g3);
        if (!m_solved) begin
            score(g1, g2, g3, a, b);
            m_a = a;
            m_b = b;
            if (a == 3) begin
                m_solved = 1; m_fails = 0; m_led = 3'b011;
            end else begin
                m_fails++;
                if (m_fails == MAX_TRY) begin
                    m_fails = 0; m_locked = 1; m_led = 3'b101;
                end else begin
                    m_led = 3'b001;
                end
            end
        end
        check("guess_a", oA, m_a);
        check("guess_b", oB, m_b);
        check("guess_led", oLED, m_led);
        if (m_locked && wait_lock) begin
            for (int k = 1; k < LOCK_LEN; k++) begin
                if (k == 2) begin
                    iNum1 = 4'd1; iNum2 = 4'd2; iNum3 = 4'd3; iNumRdy = 1'b1;
                end
                if (k == 5) iNumRdy = 1'b0;
                @(negedge CLK);
                check("lock_held", oLED[2], 1);
            end
            @(negedge CLK);
            m_locked = 0;
            m_led = 3'b001;
            check("lock_release_led", oLED, m_led);
            check("lock_keep_a", oA, m_a);
            check("lock_keep_b", oB, m_b);
        end
    endtask

    initial begin
        int g1, g2, g3;
        model_reset();
        apply_reset();

        run_guess(3, 1, 2, 1);
        check("dir_312_b", oB, 3);
        run_guess(1, 3, 9, 1);
        check("dir_139_a", oA, 1);
        check("dir_139_b", oB, 1);

        apply_reset();
        run_guess(2, 2, 2, 1);
        check("dir_222_a", oA, 1);
        check("dir_222_b", oB, 2);

        apply_reset();
        run_guess(1, 2, 4'hA, 1);
        check("dir_bad_digit_a", oA, 0);
        run_guess(4, 5, 6, 1);
        run_guess(4, 5, 6, 1);
        run_guess(1, 2, 3, 1);
        check("dir_solved_led", oLED, 3'b011);
        run_guess(4, 5, 6, 1);
        check("dir_done_hold_a", oA, 3);

        // Reset in the middle of a lockout with the ready level held high.
        apply_reset();
        run_guess(4, 5, 6, 1);
        run_guess(4, 5, 6, 1);
        run_guess(4, 5, 6, 0);
        check("mid_lock_led", oLED, 3'b101);
        iNum1 = 4'd1; iNum2 = 4'd2; iNum3 = 4'd3; iNumRdy = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("lock_reset_led", oLED, 0);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge CLK);
        check("held_rdy_a", oA, 0);
        check("held_rdy_led", oLED, 0);
        run_guess(1, 2, 3, 1);

        apply_reset();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                g1 = 1; g2 = 2; g3 = 3;
            end else begin
                g1 = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(0, 10);
                g2 = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(0, 10);
                g3 = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(0, 15);
            end
            run_guess(g1, g2, g3, 1);
            if (m_solved && $urandom_range(0, 2) == 0) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
